// File: rtl/tlc5955_pkg.sv
// Shared types and constants for the TLC5955 serial-chain controller.
package tlc5955_pkg;

    localparam int unsigned HDR_BITS       = 1;
    localparam int unsigned WORDS_PER_CHIP = 48;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_HDR   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_LAT   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tlc5955_sclk_gen.sv
// Clock divider: div_clk toggles every Div cycles while en is high, idles low otherwise.
// rise_c/fall_c flag the clk edge on which div_clk will rise/fall.
module tlc5955_sclk_gen
    import tlc5955_pkg::*;
#(
    parameter int unsigned Div = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic div_clk,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CntW = cnt_width(Div);

    logic [CntW-1:0] cnt;
    logic            tick_c;

    assign tick_c = en && (cnt == CntW'(Div - 1));
    assign rise_c = tick_c && !div_clk;
    assign fall_c = tick_c && div_clk;

    // Half-period counter; restarts low whenever disabled so each enable begins a fresh low phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (tick_c) begin
            cnt     <= '0;
            div_clk <= ~div_clk;
        end else begin
            cnt <= cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/tlc5955_shift_ctrl.sv
// Streams one frame from the frame buffer onto the TLC5955 chain: header bit per chip,
// words MSB-first on sin/sclk (descending addresses), then a lat pulse and done.
// Optional free-running gsclk output when TLC5955_GSCLK_EN is defined.
module tlc5955_shift_ctrl
    import tlc5955_pkg::*;
#(
    parameter int unsigned DataWidth    = 16,
    parameter int unsigned AddrWidth    = 8,
    parameter int unsigned WordsPerChip = WORDS_PER_CHIP,
    parameter int unsigned ClkDiv       = 2,
    parameter int unsigned LatCycles    = 4
`ifdef TLC5955_GSCLK_EN
    ,
    parameter int unsigned GsclkDiv     = 2
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 latch_sel,
    input  logic [AddrWidth-1:0] start_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 buf_set_read_addr,
    output logic [AddrWidth-1:0] buf_read_addr,
    output logic                 buf_read_next,
    input  logic [DataWidth-1:0] buf_read_data,
    input  logic                 buf_read_addr_0,
    output logic                 sclk,
    output logic                 sin,
    output logic                 lat
`ifdef TLC5955_GSCLK_EN
    ,
    output logic                 gsclk
`endif
);

    localparam int unsigned BitW  = cnt_width((DataWidth > HDR_BITS) ? DataWidth : HDR_BITS);
    localparam int unsigned ChipW = cnt_width(WordsPerChip);
    localparam int unsigned LatW  = cnt_width(LatCycles);

    state_e               state;
    logic [DataWidth-1:0] shreg;
    logic [BitW-1:0]      bit_cnt;
    logic [ChipW-1:0]     chip_cnt;
    logic [LatW-1:0]      lat_cnt;
    logic                 hdr_val;
    logic                 last_loaded;
    logic                 bit_en_c;
    logic                 bit_end_c;
    logic                 sclk_rise_unused;

    assign bit_en_c = (state == ST_HDR) || (state == ST_SHIFT);

    tlc5955_sclk_gen #(.Div(ClkDiv)) u_sclk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (bit_en_c),
        .div_clk (sclk),
        .rise_c  (sclk_rise_unused),
        .fall_c  (bit_end_c)
    );

`ifdef TLC5955_GSCLK_EN
    logic gs_rise_unused;
    logic gs_fall_unused;

    tlc5955_sclk_gen #(.Div(GsclkDiv)) u_gsclk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (1'b1),
        .div_clk (gsclk),
        .rise_c  (gs_rise_unused),
        .fall_c  (gs_fall_unused)
    );
`endif

    // Frame sequencer; sin changes only at bit-period boundaries (sclk falling).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            buf_set_read_addr <= 1'b0;
            buf_read_addr     <= '0;
            buf_read_next     <= 1'b0;
            sin               <= 1'b0;
            lat               <= 1'b0;
            shreg             <= '0;
            bit_cnt           <= '0;
            chip_cnt          <= '0;
            lat_cnt           <= '0;
            hdr_val           <= 1'b0;
            last_loaded       <= 1'b0;
        end else begin
            buf_set_read_addr <= 1'b0;
            buf_read_next     <= 1'b0;
            done              <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        buf_set_read_addr <= 1'b1;
                        buf_read_addr     <= start_addr;
                        hdr_val           <= latch_sel;
                        busy              <= 1'b1;
                        state             <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    sin     <= hdr_val;
                    bit_cnt <= '0;
                    state   <= ST_HDR;
                end
                ST_HDR: begin
                    if (bit_end_c) begin
                        if (bit_cnt == BitW'(HDR_BITS - 1)) begin
                            sin           <= buf_read_data[DataWidth-1];
                            shreg         <= {buf_read_data[DataWidth-2:0], 1'b0};
                            buf_read_next <= !buf_read_addr_0;
                            last_loaded   <= buf_read_addr_0;
                            bit_cnt       <= '0;
                            chip_cnt      <= ChipW'(WordsPerChip - 1);
                            state         <= ST_SHIFT;
                        end else begin
                            bit_cnt <= bit_cnt + BitW'(1);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bit_end_c) begin
                        if (bit_cnt != BitW'(DataWidth - 1)) begin
                            sin     <= shreg[DataWidth-1];
                            shreg   <= {shreg[DataWidth-2:0], 1'b0};
                            bit_cnt <= bit_cnt + BitW'(1);
                        end else if (last_loaded) begin
                            sin     <= 1'b0;
                            lat     <= 1'b1;
                            lat_cnt <= '0;
                            state   <= ST_LAT;
                        end else if (chip_cnt == '0) begin
                            sin     <= hdr_val;
                            bit_cnt <= '0;
                            state   <= ST_HDR;
                        end else begin
                            // Next word was prefetched when the current one was loaded.
                            sin           <= buf_read_data[DataWidth-1];
                            shreg         <= {buf_read_data[DataWidth-2:0], 1'b0};
                            buf_read_next <= !buf_read_addr_0;
                            last_loaded   <= buf_read_addr_0;
                            bit_cnt       <= '0;
                            chip_cnt      <= chip_cnt - ChipW'(1);
                        end
                    end
                end
                ST_LAT: begin
                    if (lat_cnt == LatW'(LatCycles - 1)) begin
                        lat   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + LatW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlc5955_shift_ctrl.sv
// Bench for tlc5955_shift_ctrl: buffer model, pin monitor and frame-level reference model.
// Define TLC5955_GSCLK_EN to also exercise gsclk.
module tb_tlc5955_shift_ctrl;

    localparam int DW      = 16;
    localparam int AW      = 8;
    localparam int WPC     = 2;
    localparam int CLK_DIV = 3;
    localparam int LAT_CYC = 4;
    localparam int GS_DIV  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          latch_sel = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          busy, done, buf_set_read_addr, buf_read_next;
    logic [AW-1:0] buf_read_addr;
    logic [DW-1:0] buf_read_data;
    logic          buf_read_addr_0;
    logic          sclk, sin, lat;
`ifdef TLC5955_GSCLK_EN
    logic          gsclk;
`endif

    tlc5955_shift_ctrl #(
        .DataWidth(DW), .AddrWidth(AW), .WordsPerChip(WPC), .ClkDiv(CLK_DIV), .LatCycles(LAT_CYC)
`ifdef TLC5955_GSCLK_EN
        , .GsclkDiv(GS_DIV)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .latch_sel(latch_sel), .start_addr(start_addr),
        .busy(busy), .done(done), .buf_set_read_addr(buf_set_read_addr), .buf_read_addr(buf_read_addr),
        .buf_read_next(buf_read_next), .buf_read_data(buf_read_data), .buf_read_addr_0(buf_read_addr_0),
        .sclk(sclk), .sin(sin), .lat(lat)
`ifdef TLC5955_GSCLK_EN
        , .gsclk(gsclk)
`endif
    );

    always #5 clk = ~clk;

    // Frame buffer model: address register, data valid one cycle after set/next.
    logic [DW-1:0] mem [256];
    logic [AW-1:0] cur_addr;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)               cur_addr <= '0;
        else if (buf_set_read_addr) cur_addr <= buf_read_addr;
        else if (buf_read_next)     cur_addr <= cur_addr - 8'd1;
    end
    assign buf_read_data   = mem[cur_addr];
    assign buf_read_addr_0 = (cur_addr == '0);

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pin monitor, sampled on the falling clock edge.
    bit      rise_q[$];
    int      cyc = 0, last_rise = 0;
    bit      prev_sclk = 1'b0, rise_ok = 1'b0;
    int      next_cnt = 0, set_cnt = 0, done_cnt = 0, lat_cnt = 0;
    int      bad_lat = 0, bad_period = 0, bad_wrap = 0, bad_done = 0;
    logic [AW-1:0] set_addr_seen = '0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_sclk <= sclk;
        if (!reset_n) begin
            rise_ok <= 1'b0;
        end else begin
            if (sclk && !prev_sclk) begin
                rise_q.push_back(sin);
                if (rise_ok && (cyc - last_rise) != 2 * CLK_DIV) bad_period <= bad_period + 1;
                last_rise <= cyc;
                rise_ok   <= 1'b1;
            end
            if (lat) begin
                rise_ok <= 1'b0;
                lat_cnt <= lat_cnt + 1;
                if (sclk || sin) bad_lat <= bad_lat + 1;
            end
            if (buf_read_next) begin
                next_cnt <= next_cnt + 1;
                if (cur_addr == '0) bad_wrap <= bad_wrap + 1;
            end
            if (buf_set_read_addr) begin
                set_cnt       <= set_cnt + 1;
                set_addr_seen <= buf_read_addr;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (busy) bad_done <= bad_done + 1;
            end
        end
    end

    // One frame: start, optional start hammering while busy, start on the done cycle, then verify.
    task automatic run_frame(input logic [AW-1:0] sa, input logic ls, input bit hammer, input string nm);
        int q0, n0, s0, d0, l0, bl0, bp0, bw0, bd0, nbad, n, exp_rises;
        bit seen;
        bit exp_q[$];
        logic [DW-1:0] w;
        q0 = rise_q.size(); n0 = next_cnt; s0 = set_cnt; d0 = done_cnt; l0 = lat_cnt;
        bl0 = bad_lat; bp0 = bad_period; bw0 = bad_wrap; bd0 = bad_done;
        start_addr = sa; latch_sel = ls; start = 1'b1;
        @(negedge clk);
        start = 1'b0; latch_sel = ~ls; start_addr = AW'($urandom);
        check({nm, "_busy_up"}, busy, 1);
        seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            start = hammer ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        check({nm, "_done_seen"}, seen, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        // Reference stream: header before every WPC-th word, words MSB-first, descending addresses.
        n = int'(sa) + 1;
        for (int k = 0; k < n; k++) begin
            if (k % WPC == 0) exp_q.push_back(ls);
            w = mem[int'(sa) - k];
            for (int b = DW - 1; b >= 0; b--) exp_q.push_back(w[b]);
        end
        exp_rises = (n + WPC - 1) / WPC + n * DW;
        check({nm, "_rises"}, rise_q.size() - q0, exp_rises);
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (q0 + i < rise_q.size() && rise_q[q0 + i] != exp_q[i]) nbad++;
        check({nm, "_bit_errs"}, nbad, 0);
        check({nm, "_read_next"}, next_cnt - n0, n - 1);
        check({nm, "_set_cnt"}, set_cnt - s0, 1);
        check({nm, "_set_addr"}, set_addr_seen, sa);
        check({nm, "_done_cnt"}, done_cnt - d0, 1);
        check({nm, "_lat_cycles"}, lat_cnt - l0, LAT_CYC);
        check({nm, "_lat_pins"}, bad_lat - bl0, 0);
        check({nm, "_bit_period"}, bad_period - bp0, 0);
        check({nm, "_no_wrap"}, bad_wrap - bw0, 0);
        check({nm, "_done_busy"}, bad_done - bd0, 0);
        check({nm, "_busy_end"}, busy, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    endtask

    initial begin
        fill_random();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pins", {sclk, sin, lat, done}, 0);
        check("rst_strobes", {buf_set_read_addr, buf_read_next}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        mem[1] = 16'hA5A5; mem[0] = 16'h0001;
        run_frame(8'd1, 1'b0, 1'b0, "two_words");
        run_frame(8'd3, 1'b1, 1'b0, "four_words");
        run_frame(8'd0, 1'b1, 1'b0, "one_word");
        run_frame(8'd4, 1'b0, 1'b1, "hammer");

        // Asynchronous reset in the middle of shifting.
        start_addr = 8'd5; latch_sel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_pins", {sclk, sin, lat, done}, 0);
        check("midrst_strobes", {buf_set_read_addr, buf_read_next}, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_idle", {busy, sclk, lat}, 0);
        run_frame(8'd5, 1'b1, 1'b0, "after_rst");

        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_frame(AW'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end
        fill_random();
        run_frame(8'd20, 1'b0, 1'b0, "long");

`ifdef TLC5955_GSCLK_EN
        begin
            logic g0;
            int   gap;
            bit   got;
            for (int t = 0; t < 4; t++) begin
                g0 = gsclk; got = 1'b0; gap = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (gsclk != g0) begin got = 1'b1; break; end
                end
                g0 = gsclk;
                for (int i = 1; i <= 50; i++) begin
                    @(negedge clk);
                    if (gsclk != g0) begin gap = i; break; end
                end
                check("gsclk_toggle", got, 1);
                check("gsclk_half", gap, GS_DIV);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
